// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - parallel-to-serial word transmitter feeding the bit-serial complementer
module serial_word_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             t_clk,
    input  logic             r_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             abort,
    output logic             sout,
    output logic             sclr,
    output logic             sframe,
    output logic             slast,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT_BIT = CW'(WIDTH - 2);
    localparam logic [3:0] LAST_GAP = 4'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLR, S_SHIFT, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [3:0]       gapcnt_q, gapcnt_d;
    logic             sout_q, sout_d;
    logic             sclr_q, sclr_d;
    logic             sframe_q, sframe_d;
    logic             slast_q, slast_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        sout_d   = 1'b0;
        sclr_d   = 1'b0;
        sframe_d = 1'b0;
        slast_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    state_d = S_CLR;
                    shreg_d = din;
                    sclr_d  = 1'b1;
                end
            end
            S_CLR: begin
                state_d  = S_SHIFT;
                bitcnt_d = '0;
                sout_d   = shreg_q[0];
                shreg_d  = shreg_q >> 1;
                sframe_d = 1'b1;
            end
            S_SHIFT: begin
                // Outputs are registered, so bit i+1 is launched while bit i is on the line.
                if (bitcnt_q == LAST_BIT) begin
                    gapcnt_d = '0;
                    state_d  = (GAP != 0) ? S_GAP : S_IDLE;
                end else begin
                    bitcnt_d = bitcnt_q + 1'b1;
                    sout_d   = shreg_q[0];
                    shreg_d  = shreg_q >> 1;
                    sframe_d = 1'b1;
                    slast_d  = (bitcnt_q == PENULT_BIT);
                end
            end
            S_GAP: begin
                if (gapcnt_q == LAST_GAP) begin
                    state_d = S_IDLE;
                end else begin
                    gapcnt_d = gapcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            sout_d   = 1'b0;
            sclr_d   = 1'b0;
            sframe_d = 1'b0;
            slast_d  = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            sout_q   <= 1'b0;
            sclr_q   <= 1'b0;
            sframe_q <= 1'b0;
            slast_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            sout_q   <= sout_d;
            sclr_q   <= sclr_d;
            sframe_q <= sframe_d;
            slast_q  <= slast_d;
            busy_q   <= busy_d;
        end
    end

    assign din_ready = (state_q == S_IDLE);
    assign sout      = sout_q;
    assign sclr      = sclr_q;
    assign sframe    = sframe_q;
    assign slast     = slast_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - checks serial_word_tx (GAP=1 and GAP=0) against a frame-schedule model
module tb_serial_word_tx;
    localparam int W = 8;

    logic         t_clk = 1'b0;
    logic         r_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         abort;
    logic [1:0]   din_ready, sout, sclr, sframe, slast, busy;

    serial_word_tx #(.WIDTH(W), .GAP(1)) u_dut_g1 (
        .t_clk(t_clk), .r_n(r_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready[0]), .abort(abort), .sout(sout[0]), .sclr(sclr[0]),
        .sframe(sframe[0]), .slast(slast[0]), .busy(busy[0])
    );

    serial_word_tx #(.WIDTH(W), .GAP(0)) u_dut_g0 (
        .t_clk(t_clk), .r_n(r_n), .din(din), .din_valid(din_valid),
        .din_ready(din_ready[1]), .abort(abort), .sout(sout[1]), .sclr(sclr[1]),
        .sframe(sframe[1]), .slast(slast[1]), .busy(busy[1])
    );

    initial forever #5 t_clk = ~t_clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int gp[2] = '{1, 0};

    // Model: a word is "active" for W+GAP+1 cycles after its accept edge; ph counts those cycles.
    bit           m_act[2];
    int           m_ph[2];
    logic [W-1:0] m_word[2];

    typedef struct {
        logic [W-1:0] d;
        bit v, ab;
        bit e_sout, e_sclr, e_sframe, e_slast, e_busy, e_ready;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input int k);
        if (!m_act[k]) begin
            if (din_valid) begin
                m_act[k]  = 1'b1;
                m_ph[k]   = 1;
                m_word[k] = din;
            end
        end else if (abort) begin
            m_act[k] = 1'b0;
        end else begin
            m_ph[k]++;
            if (m_ph[k] == W + gp[k] + 2) m_act[k] = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            bit fr;
            bit e_sout;
            fr = m_act[k] && (m_ph[k] >= 2) && (m_ph[k] <= W + 1);
            e_sout = fr ? m_word[k][m_ph[k]-2] : 1'b0;
            chk($sformatf("%s.d%0d.busy", tag, k), busy[k], m_act[k]);
            chk($sformatf("%s.d%0d.ready", tag, k), din_ready[k], !m_act[k]);
            chk($sformatf("%s.d%0d.sclr", tag, k), sclr[k], m_act[k] && m_ph[k] == 1);
            chk($sformatf("%s.d%0d.sframe", tag, k), sframe[k], fr);
            chk($sformatf("%s.d%0d.slast", tag, k), slast[k], m_act[k] && m_ph[k] == W + 1);
            chk($sformatf("%s.d%0d.sout", tag, k), sout[k], e_sout);
        end
    endtask

    task automatic step(input string tag);
        @(posedge t_clk);
        if (r_n) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        cyc++;
        check_outputs(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.d%0d.busy", tag, k), busy[k], 0);
            chk($sformatf("%s.d%0d.ready", tag, k), din_ready[k], 1);
            chk($sformatf("%s.d%0d.sclr", tag, k), sclr[k], 0);
            chk($sformatf("%s.d%0d.sframe", tag, k), sframe[k], 0);
            chk($sformatf("%s.d%0d.slast", tag, k), slast[k], 0);
            chk($sformatf("%s.d%0d.sout", tag, k), sout[k], 0);
        end
    endtask

    function automatic logic [W-1:0] serial_negate(input logic [W-1:0] bits);
        logic [W-1:0] r;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < W; i++) begin
            r[i] = seen ? ~bits[i] : bits[i];
            if (bits[i]) seen = 1'b1;
        end
        return r;
    endfunction

    initial begin
        logic [W-1:0] b4;
        logic [W-1:0] cap;
        int q0[$];
        int q1[$];
        bit prev_slast;

        r_n = 1'b0; din = '0; din_valid = 1'b1; abort = 1'b0;
        m_act = '{0, 0}; m_ph = '{0, 0}; m_word = '{0, 0};
        #2;
        check_reset_vals("reset");
        din_valid = 1'b0;
        #10 r_n = 1'b1;
        for (int i = 0; i < 5; i++) step("idle");

        b4 = 8'hB4;
        tbl[0] = '{b4, 1, 0, 0, 1, 0, 0, 1, 0};
        for (int i = 1; i <= 8; i++) tbl[i] = '{8'h00, 0, 0, b4[i-1], 0, 1, (i == 8), 1, 0};
        tbl[9]  = '{8'h00, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[10] = '{8'h00, 0, 0, 0, 0, 0, 0, 0, 1};
        cap = '0;
        for (int i = 0; i < 11; i++) begin
            din = tbl[i].d; din_valid = tbl[i].v; abort = tbl[i].ab;
            step("b4");
            chk($sformatf("tbl%0d.sout", i), sout[0], tbl[i].e_sout);
            chk($sformatf("tbl%0d.sclr", i), sclr[0], tbl[i].e_sclr);
            chk($sformatf("tbl%0d.sframe", i), sframe[0], tbl[i].e_sframe);
            chk($sformatf("tbl%0d.slast", i), slast[0], tbl[i].e_slast);
            chk($sformatf("tbl%0d.busy", i), busy[0], tbl[i].e_busy);
            chk($sformatf("tbl%0d.ready", i), din_ready[0], tbl[i].e_ready);
            if (i >= 1 && i <= 8) cap[i-1] = sout[0];
        end
        chk("b4_complemented", serial_negate(cap), 8'h4C);

        din = 8'h01; din_valid = 1'b1; prev_slast = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step("hold");
            if (i == 0) din = 8'hFF;
            if (sclr[0]) q0.push_back(cyc);
            if (sclr[1]) q1.push_back(cyc);
            if (prev_slast) chk("g0_idle_after_slast", {busy[1], din_ready[1]}, 2'b01);
            prev_slast = slast[1];
        end
        chk("hold_period_gap1", (q0.size() >= 2) ? q0[1] - q0[0] : 0, 11);
        chk("hold_period_gap0", (q1.size() >= 2) ? q1[1] - q1[0] : 0, 10);
        din_valid = 1'b0;
        for (int i = 0; i < 12; i++) step("drain1");

        din = 8'hA5; din_valid = 1'b1;
        step("abort_acc");
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++) step("abort_bits");
        abort = 1'b1;
        step("abort");
        abort = 1'b0;
        chk("abort_sframe", sframe[0], 0);
        chk("abort_sout", sout[0], 0);
        chk("abort_busy", busy[0], 0);
        chk("abort_ready", din_ready[0], 1);
        din = 8'h3C; din_valid = 1'b1;
        step("post_abort");
        din_valid = 1'b0;
        chk("post_abort_sclr", sclr[0], 1);
        for (int i = 0; i < 12; i++) step("drain2");

        din = 8'h5A; din_valid = 1'b1;
        step("rst_acc");
        din_valid = 1'b0;
        step("rst_b0");
        step("rst_b1");
        #2 r_n = 1'b0;
        #1 check_reset_vals("async_rst");
        m_act = '{0, 0};
        #3 r_n = 1'b1;
        for (int i = 0; i < 12; i++) step("post_rst");

        for (int i = 0; i < 500; i++) begin
            din = W'($urandom);
            din_valid = ($urandom % 3) == 0;
            abort = ($urandom % 12) == 0;
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
